// File: rtl/wrr_pkt_arb_if.sv
// Handshake bundle between the four input ports and the packet arbiter of one output port.
// master = requester/downstream side, slave = arbiter side.
interface wrr_pkt_arb_if #(
    parameter int WBITS = 3
);
    logic [3:0]         req;
    logic [3:0]         vld;
    logic [3:0]         last;
    logic [4*WBITS-1:0] weight;
    logic               out_rdy;
    logic               out_vld;
    logic [3:0]         gnt;
    logic [2:0]         sel;
    logic [1:0]         lead;
    logic               err;

    modport master (
        output req, vld, last, weight, out_rdy,
        input  out_vld, gnt, sel, lead, err
    );

    modport slave (
        input  req, vld, last, weight, out_rdy,
        output out_vld, gnt, sel, lead, err
    );
endinterface

// File: rtl/wrr_pkt_arb.sv
// Packet-level weighted round-robin arbiter for one output port.
// A grant is held from the first flit to the last one, or until the packet is cut off at MAXLEN flits.
//   state | meaning
//   IDLE  | no grant; pick the winner starting at lead
//   BUSY  | input sel-1 owns the output until last, MAXLEN cut-off or req drop
module wrr_pkt_arb #(
    parameter int WBITS  = 3,
    parameter int MAXLEN = 16,
    parameter int LBITS  = 5
) (
    input  logic          clk,
    input  logic          rst,
    wrr_pkt_arb_if.slave  bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [1:0]         lead_q, lead_d;
    logic               err_q, err_d;
    logic [WBITS-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [WBITS-1:0]   cur_w_q, cur_w_d;
    logic [LBITS-1:0]   flit_cnt_q, flit_cnt_d;

    logic [1:0]         gidx;
    logic               busy;
    logic               out_vld;
    logic               accept;
    logic               flit_last;
    logic               at_maxlen;
    logic               turn_done;
    logic [1:0]         win;
    logic               win_vld;
    logic [WBITS-1:0]   win_w;

    // In IDLE sel is 0, so gidx wraps to 3; every use is gated by busy.
    assign gidx      = 2'(sel_q - 3'd1);
    assign busy      = (state_q == BUSY);
    assign out_vld   = busy && bus.vld[gidx];
    assign accept    = out_vld && bus.out_rdy;
    assign flit_last = bus.last[gidx];
    assign at_maxlen = (flit_cnt_q == LBITS'(MAXLEN - 1));
    assign turn_done = ({1'b0, pkt_cnt_q} + {{WBITS{1'b0}}, 1'b1}) >= {1'b0, cur_w_q};

    // Scan from lead+3 down to lead so the closest requester to lead is the final assignment.
    always_comb begin
        win     = lead_q;
        win_vld = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[lead_q + 2'(k)]) begin
                win     = lead_q + 2'(k);
                win_vld = 1'b1;
            end
        end
    end

    assign win_w = bus.weight[win*WBITS +: WBITS];

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        lead_d     = lead_q;
        err_d      = 1'b0;
        pkt_cnt_d  = pkt_cnt_q;
        cur_w_d    = cur_w_q;
        flit_cnt_d = flit_cnt_q;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d    = BUSY;
                    sel_d      = {1'b0, win} + 3'd1;
                    gnt_d      = 4'b0001 << win;
                    flit_cnt_d = '0;
                    cur_w_d    = (win_w == '0) ? WBITS'(1) : win_w;
                    if (win != lead_q) begin
                        pkt_cnt_d = '0;
                        lead_d    = win;
                    end
                end
            end
            BUSY: begin
                if (accept) begin
                    flit_cnt_d = flit_cnt_q + LBITS'(1);
                    if (flit_last) begin
                        state_d = IDLE;
                        sel_d   = 3'd0;
                        gnt_d   = 4'b0000;
                        if (turn_done) begin
                            pkt_cnt_d = '0;
                            lead_d    = gidx + 2'd1;
                        end else begin
                            pkt_cnt_d = pkt_cnt_q + WBITS'(1);
                        end
                    end else if (at_maxlen) begin
                        state_d   = IDLE;
                        sel_d     = 3'd0;
                        gnt_d     = 4'b0000;
                        pkt_cnt_d = '0;
                        lead_d    = gidx + 2'd1;
                        err_d     = 1'b1;
                    end
                end else if (!bus.req[gidx]) begin
                    // Requester withdrew mid-packet: give up the rest of its turn, no error.
                    state_d   = IDLE;
                    sel_d     = 3'd0;
                    gnt_d     = 4'b0000;
                    pkt_cnt_d = '0;
                    lead_d    = gidx + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 3'd0;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= 3'd0;
            gnt_q      <= 4'b0000;
            lead_q     <= 2'd0;
            err_q      <= 1'b0;
            pkt_cnt_q  <= '0;
            cur_w_q    <= '0;
            flit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            lead_q     <= lead_d;
            err_q      <= err_d;
            pkt_cnt_q  <= pkt_cnt_d;
            cur_w_q    <= cur_w_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

    assign bus.out_vld = out_vld;
    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.lead    = lead_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_wrr_pkt_arb.sv
// Directed bench for wrr_pkt_arb: expected grant order is queued as stimulus is set up
// and popped as each grant appears.
module tb_wrr_pkt_arb;
    localparam int WBITS  = 3;
    localparam int MAXLEN = 4;
    localparam int LBITS  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wrr_pkt_arb_if #(.WBITS(WBITS)) bus ();

    wrr_pkt_arb #(.WBITS(WBITS), .MAXLEN(MAXLEN), .LBITS(LBITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req     = 4'b0000;
        bus.vld     = 4'b0000;
        bus.last    = 4'b0000;
        bus.out_rdy = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        check("rst_sel",  32'(bus.sel),  32'd0);
        check("rst_gnt",  32'(bus.gnt),  32'd0);
        check("rst_lead", 32'(bus.lead), 32'd0);
        check("rst_err",  32'(bus.err),  32'd0);
        check("rst_ovld", 32'(bus.out_vld), 32'd0);
        rst = 1'b0;
    endtask

    // Waits (bounded) for a grant, pops the expected input and checks it arrived after one cycle.
    task automatic expect_grant(input string tag, output int w);
        int cyc;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            cyc++;
            if (|bus.gnt) break;
        end
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
        check({tag, "_seen"}, 32'(|bus.gnt), 32'd1);
        check({tag, "_gnt"},  32'(bus.gnt), 32'(4'b0001 << w));
        check({tag, "_sel"},  32'(bus.sel), 32'(w + 1));
        check({tag, "_lat"},  32'(cyc), 32'd1);
    endtask

    task automatic send_pkt(input int idx, input int n);
        bus.out_rdy = 1'b1;
        for (int k = 0; k < n; k++) begin
            bus.vld[idx]  = 1'b1;
            bus.last[idx] = (k == n - 1);
            #1;
            check("pkt_ovld", 32'(bus.out_vld), 32'd1);
            step();
            check("pkt_hold", 32'(bus.gnt[idx]), 32'(k != n - 1));
        end
        bus.vld[idx]  = 1'b0;
        bus.last[idx] = 1'b0;
    endtask

    initial begin
        int w;
        clear_inputs();
        bus.weight = {3'd1, 3'd1, 3'd1, 3'd1};

        // Equal weights, 2-flit packets from all four inputs
        do_reset();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        bus.req = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            expect_grant("eq", w);
            send_pkt(w, 2);
            check("eq_lead", 32'(bus.lead), 32'((w + 1) % 4));
        end

        // Weighted turns: weight0=3 then weight0=0 (acts as 1)
        do_reset();
        bus.weight = {3'd1, 3'd1, 3'd1, 3'd3};
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
        end
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
        bus.req = 4'b0011;
        for (int p = 0; p < 12; p++) begin
            expect_grant("wrr", w);
            send_pkt(w, 1);
            if (p == 7) bus.weight = {3'd1, 3'd1, 3'd1, 3'd0};
        end

        // Backpressure on a 3-flit packet from input 0
        do_reset();
        bus.weight = {3'd1, 3'd1, 3'd1, 3'd1};
        exp_q.push_back(0);
        bus.req = 4'b0001;
        expect_grant("bp", w);
        bus.vld[0] = 1'b1;
        step();
        bus.out_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.vld[0] = c[0];
            #1;
            check("bp_ovld", 32'(bus.out_vld), 32'(c[0]));
            step();
            check("bp_hold", 32'(bus.gnt[0]), 32'd1);
        end
        bus.out_rdy = 1'b1;
        bus.vld[0]  = 1'b1;
        step();
        check("bp_hold2", 32'(bus.gnt[0]), 32'd1);
        bus.last[0] = 1'b1;
        step();
        check("bp_end", 32'(bus.gnt[0]), 32'd0);
        bus.vld[0]  = 1'b0;
        bus.last[0] = 1'b0;
        bus.req     = 4'b0000;

        // MAXLEN cut-off on input 2, input 3 waiting
        do_reset();
        exp_q.push_back(2);
        bus.req = 4'b1100;
        expect_grant("ml", w);
        bus.vld[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("ml_err",  32'(bus.err),    32'(k == 3));
            check("ml_gnt2", 32'(bus.gnt[2]), 32'(k != 3));
        end
        check("ml_lead", 32'(bus.lead), 32'd3);
        bus.vld[2] = 1'b0;
        exp_q.push_back(3);
        expect_grant("ml_next", w);
        check("ml_err_once", 32'(bus.err), 32'd0);

        // Abort: input 1 drops req after one flit, input 3 waiting
        do_reset();
        exp_q.push_back(1);
        bus.req = 4'b1010;
        expect_grant("ab", w);
        bus.vld[1] = 1'b1;
        step();
        bus.vld[1] = 1'b0;
        bus.req    = 4'b1000;
        #1;
        check("ab_ovld", 32'(bus.out_vld), 32'd0);
        step();
        check("ab_sel",  32'(bus.sel),  32'd0);
        check("ab_lead", 32'(bus.lead), 32'd2);
        check("ab_err",  32'(bus.err),  32'd0);
        exp_q.push_back(3);
        expect_grant("ab_next", w);
        check("ab_err2", 32'(bus.err), 32'd0);

        // Reset mid-packet while input 3 is busy with lead=3
        bus.req    = 4'b1010;
        bus.vld[3] = 1'b1;
        step();
        rst = 1'b1;
        step();
        check("mr_sel",  32'(bus.sel),  32'd0);
        check("mr_gnt",  32'(bus.gnt),  32'd0);
        check("mr_lead", 32'(bus.lead), 32'd0);
        check("mr_err",  32'(bus.err),  32'd0);
        check("mr_ovld", 32'(bus.out_vld), 32'd0);
        rst        = 1'b0;
        bus.vld[3] = 1'b0;
        exp_q.push_back(1);
        expect_grant("mr_next", w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wrr_pkt_arb.md
Name: wrr_pkt_arb

Overview:
- Packet-level weighted round-robin scheduler for one output port of the 4-way switch.
- Shares the output among input0..input3 and holds a grant for a whole multi-flit packet, from the first accepted flit to the flit marked last.
- A requester may send up to its programmed weight of packets in a row before priority rotates.
- Drives the output valid/ready handshake and the per-input grants. Also enforces a maximum packet length.

Parameters:
- WBITS, 3, width of each per-input weight field (packets per turn).
- MAXLEN, 16, maximum flits per packet before forced termination.
- LBITS, 5, width of the flit counter; must satisfy 2^LBITS > MAXLEN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  per-input packet request; bit i from input i. Held high until the packet is done.
- vld  input  4  per-input flit valid.
- last  input  4  per-input last-flit marker; qualified by vld.
- weight  input  4*WBITS  weights; bits [i*WBITS +: WBITS] belong to input i. A value of 0 is treated as 1.
- out_rdy  input  1  downstream ready.
- out_vld  output  1  flit valid toward output = (state==BUSY) && vld[sel-1]; combinational.
- gnt  output  4  one-hot registered grant; gnt[i] = (state==BUSY && sel==i+1).
- sel  output  3  granted input, 1-indexed; 0 = none. Registered.
- lead  output  2  current round-robin head. Registered.
- err  output  1  one-cycle pulse on forced termination. Registered.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, sel=0, gnt=0, lead=0, pkt_cnt=0, flit_cnt=0, err=0, cur_w=0. Reset asserted mid-packet aborts immediately; no completion bookkeeping is done.
- States: IDLE and BUSY.
- IDLE arbitration:
  - If any req bit is set, the winner w is the first set bit in the order lead, lead+1, lead+2, lead+3 (mod 4).
  - Next cycle: state=BUSY, sel=w+1, flit_cnt=0, cur_w=max(weight[w],1) (weight sampled here).
  - If w != lead: pkt_cnt=0 and lead=w.
  - If no req is set: hold all registers.
- Grant latency: req rising in IDLE gives gnt on the next edge. out_vld can rise in the first BUSY cycle.
- Flit accept: out_vld && out_rdy. Each accept does flit_cnt+1. If vld is high and out_rdy is low, nothing changes.
- Packet end: an accept with last[sel-1]=1. Next cycle:
  - state=IDLE, sel=0.
  - If pkt_cnt+1 >= cur_w: pkt_cnt=0 and lead=(w+1)%4.
  - Otherwise: pkt_cnt=pkt_cnt+1 and lead is unchanged, so w wins again if it is still requesting.
- Bubble: exactly one IDLE cycle between consecutive packets. gnt is low for that cycle.
- Forced end: an accept without last while flit_cnt==MAXLEN-1.
  - Same next-state as a packet end, except lead=(w+1)%4 and pkt_cnt=0 unconditionally.
  - err=1 for one cycle.
- Abort: req[sel-1]=0 while in BUSY with no accept that cycle.
  - Next: IDLE, sel=0, lead=(w+1)%4, pkt_cnt=0.
  - Abort does not pulse err.
- Simultaneous req drop and accept-with-last in one cycle: treated as a normal packet end.
- Only the granted input's vld and last are observed. Other inputs' vld and last are ignored.
- Weight changes during BUSY take effect only at the next grant.
- Arithmetic:
  - lead wraps modulo 4 (2 bits).
  - pkt_cnt is WBITS wide and never exceeds cur_w-1.
  - flit_cnt saturates logically through the forced-end rule, so it never wraps.

Test Plan:
- Equal weights: weight=1 for all, req=4'b1111, each packet 2 flits, out_rdy=1. Required sel sequence 1,2,3,4,1; each grant lasts 2 cycles with a 1-cycle bubble; lead after the 4th packet = 0.
- Weighted turns: weight0=3, weight1=1, req0 and req1 held, 1-flit packets. Grant order 0,0,0,1,0,0,0,1; weight0=0 behaves as 1.
- Backpressure: in0 granted with a 3-flit packet, out_rdy low for 4 cycles after the first flit. gnt0 held throughout, out_vld follows vld0, and the packet ends only after the 3rd accept.
- MAXLEN=4, in2 streams flits with last never set. After 4 accepts: err pulses exactly once, gnt2 drops, lead=3; in3 (requesting) is granted next.
- Abort: in1 granted, req1 dropped after 1 flit, in3 requesting. Next cycle IDLE with lead=2, then sel=4; err stays 0.
- Reset mid-packet: rst high for 1 cycle during BUSY. All outputs return to reset values on that edge, and arbitration restarts from lead=0.
